// File: rtl/accum_ctrl8_if.sv
// rtl/accum_ctrl8_if.sv - command, add/sub unit and result bundle for accum_ctrl8
interface accum_ctrl8_if #(
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [7:0]       cmd_data;
    logic [7:0]       add_a;
    logic [7:0]       add_b;
    logic             add_sub;
    logic [7:0]       add_s;
    logic             add_ovfl;
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_data;
    logic             res_ovfl;
    logic             sticky_ovfl;
    logic [CNT_W-1:0] op_count;

    // Accumulator controller side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, add_s, add_ovfl, res_ready,
        output cmd_ready, add_a, add_b, add_sub, res_valid, res_data,
               res_ovfl, sticky_ovfl, op_count
    );

    // Command source, add/sub unit and result consumer side.
    modport master (
        output cmd_valid, cmd_op, cmd_data, add_s, add_ovfl, res_ready,
        input  cmd_ready, add_a, add_b, add_sub, res_valid, res_data,
               res_ovfl, sticky_ovfl, op_count
    );
endinterface

// File: rtl/accum_ctrl8.sv
// rtl/accum_ctrl8.sv - 8-bit accumulator controller driving an external add/sub unit
module accum_ctrl8 #(
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    accum_ctrl8_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_next;

    logic [1:0]       op_q;
    logic [7:0]       data_q;
    logic [7:0]       acc_q;
    logic [7:0]       res_data_q;
    logic             res_ovfl_q;
    logic             sticky_q;
    logic [CNT_W-1:0] cnt_q;

    logic             cmd_ready_c;
    logic             res_valid_c;
    logic [7:0]       add_a_c;
    logic [7:0]       add_b_c;
    logic             add_sub_c;
    logic             cmd_fire;
    logic             is_arith;

    assign cmd_fire = bus.cmd_valid && cmd_ready_c;
    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake / add-unit drive for the current state.
    always_comb begin
        state_next  = state;
        cmd_ready_c = 1'b0;
        res_valid_c = 1'b0;
        add_a_c     = acc_q;
        add_b_c     = 8'h00;
        add_sub_c   = 1'b0;
        case (state)
            IDLE: begin
                // Held low while reset is asserted so no command is taken then.
                cmd_ready_c = rst_n;
                if (bus.cmd_valid && rst_n) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                add_b_c    = data_q;
                add_sub_c  = (op_q == OP_SUB);
                state_next = RESP;
            end
            RESP: begin
                res_valid_c = 1'b1;
                if (bus.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command capture, accumulator update and result/status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q       <= OP_LOAD;
            data_q     <= 8'h00;
            acc_q      <= 8'h00;
            res_data_q <= 8'h00;
            res_ovfl_q <= 1'b0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (cmd_fire) begin
                op_q   <= bus.cmd_op;
                data_q <= bus.cmd_data;
            end
            if (state == EXEC) begin
                case (op_q)
                    OP_LOAD: begin
                        acc_q      <= data_q;
                        res_data_q <= data_q;
                    end
                    OP_CLR: begin
                        acc_q      <= 8'h00;
                        res_data_q <= 8'h00;
                    end
                    default: begin
                        acc_q      <= bus.add_s;
                        res_data_q <= bus.add_s;
                    end
                endcase
                res_ovfl_q <= is_arith && bus.add_ovfl;
                // CLR is the only command that drops the sticky flag; LOAD keeps it.
                if (op_q == OP_CLR) begin
                    sticky_q <= 1'b0;
                end else if (is_arith && bus.add_ovfl) begin
                    sticky_q <= 1'b1;
                end
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + CNT_ONE;
                end
            end
        end
    end

    assign bus.cmd_ready   = cmd_ready_c;
    assign bus.res_valid   = res_valid_c;
    assign bus.add_a       = add_a_c;
    assign bus.add_b       = add_b_c;
    assign bus.add_sub     = add_sub_c;
    assign bus.res_data    = res_data_q;
    assign bus.res_ovfl    = res_ovfl_q;
    assign bus.sticky_ovfl = sticky_q;
    assign bus.op_count    = cnt_q;
endmodule

// File: tb/tb_accum_ctrl8.sv
// tb/tb_accum_ctrl8.sv - scoreboard bench for accum_ctrl8 (CNT_W=8 and CNT_W=2 in lockstep)
module tb_accum_ctrl8;
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef struct {
        logic [7:0] data;
        logic       ovfl;
        logic       sticky;
        logic [7:0] cnt8;
        logic [1:0] cnt2;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int vectors = 0;
    int fails = 0;

    exp_t sb[$];

    logic [7:0] acc_m = 8'h00;
    logic       sticky_m = 1'b0;
    logic [7:0] cnt8_m = 8'h00;
    logic [1:0] cnt2_m = 2'd0;

    accum_ctrl8_if #(.CNT_W(8)) bus8 ();
    accum_ctrl8_if #(.CNT_W(2)) bus2 ();

    accum_ctrl8 #(.CNT_W(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    accum_ctrl8 #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // External combinational add/sub units.
    assign bus8.add_s    = bus8.add_sub ? bus8.add_a - bus8.add_b : bus8.add_a + bus8.add_b;
    assign bus8.add_ovfl = bus8.add_sub
        ? ((bus8.add_a[7] != bus8.add_b[7]) && (bus8.add_s[7] != bus8.add_a[7]))
        : ((bus8.add_a[7] == bus8.add_b[7]) && (bus8.add_s[7] != bus8.add_a[7]));
    assign bus2.add_s    = bus2.add_sub ? bus2.add_a - bus2.add_b : bus2.add_a + bus2.add_b;
    assign bus2.add_ovfl = bus2.add_sub
        ? ((bus2.add_a[7] != bus2.add_b[7]) && (bus2.add_s[7] != bus2.add_a[7]))
        : ((bus2.add_a[7] == bus2.add_b[7]) && (bus2.add_s[7] != bus2.add_a[7]));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] d);
        bus8.cmd_valid = v;
        bus8.cmd_op    = op;
        bus8.cmd_data  = d;
        bus2.cmd_valid = v;
        bus2.cmd_op    = op;
        bus2.cmd_data  = d;
    endtask

    task automatic set_ready(input logic r);
        bus8.res_ready = r;
        bus2.res_ready = r;
    endtask

    task automatic model_reset();
        acc_m    = 8'h00;
        sticky_m = 1'b0;
        cnt8_m   = 8'h00;
        cnt2_m   = 2'd0;
        sb.delete();
    endtask

    // Called at a negedge with the block in IDLE; returns at the negedge inside EXEC.
    task automatic send(input logic [1:0] op, input logic [7:0] d);
        exp_t e;
        int ai, bi, r;
        logic [7:0] acc_before;
        acc_before = acc_m;
        ai = int'($signed(acc_m));
        bi = int'($signed(d));
        e.ovfl = 1'b0;
        case (op)
            OP_LOAD: acc_m = d;
            OP_CLR: begin
                acc_m    = 8'h00;
                sticky_m = 1'b0;
            end
            default: begin
                r      = (op == OP_SUB) ? ai - bi : ai + bi;
                e.ovfl = (r > 127) || (r < -128);
                acc_m  = r[7:0];
                if (e.ovfl) sticky_m = 1'b1;
            end
        endcase
        if (cnt8_m != 8'hFF) cnt8_m = cnt8_m + 8'd1;
        if (cnt2_m != 2'd3) cnt2_m = cnt2_m + 2'd1;
        e.data   = acc_m;
        e.sticky = sticky_m;
        e.cnt8   = cnt8_m;
        e.cnt2   = cnt2_m;
        sb.push_back(e);

        check("cmd_ready_idle", 32'(bus8.cmd_ready), 32'd1);
        drive(1'b1, op, d);
        @(negedge clk);
        drive(1'b0, 2'b11, 8'hA5);
        check("cmd_ready_exec", 32'(bus8.cmd_ready), 32'd0);
        check("add_a_exec", 32'(bus8.add_a), 32'(acc_before));
        check("add_b_exec", 32'(bus8.add_b), 32'(d));
        check("add_sub_exec", 32'(bus8.add_sub), 32'(op == OP_SUB));
    endtask

    // Waits for the result, compares against the scoreboard, optionally stalls.
    task automatic recv(input int stall);
        exp_t e;
        int n;
        n = 0;
        while (!bus8.res_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'd1);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check("res_data", 32'(bus8.res_data), 32'(e.data));
        check("res_ovfl", 32'(bus8.res_ovfl), 32'(e.ovfl));
        check("sticky_ovfl", 32'(bus8.sticky_ovfl), 32'(e.sticky));
        check("op_count8", 32'(bus8.op_count), 32'(e.cnt8));
        check("op_count2", 32'(bus2.op_count), 32'(e.cnt2));
        check("res_data2", 32'(bus2.res_data), 32'(e.data));
        check("add_b_resp", 32'(bus8.add_b), 32'd0);
        check("add_sub_resp", 32'(bus8.add_sub), 32'd0);
        for (int i = 0; i < stall; i++) begin
            drive(1'b0, 2'(i), 8'(8'h40 + i));
            @(negedge clk);
            check("stall_valid", 32'(bus8.res_valid), 32'd1);
            check("stall_data", 32'(bus8.res_data), 32'(e.data));
            check("stall_ovfl", 32'(bus8.res_ovfl), 32'(e.ovfl));
            check("stall_cmd_ready", 32'(bus8.cmd_ready), 32'd0);
        end
        set_ready(1'b1);
        @(negedge clk);
        check("post_valid", 32'(bus8.res_valid), 32'd0);
        check("post_cmd_ready", 32'(bus8.cmd_ready), 32'd1);
        check("acc_idle", 32'(bus8.add_a), 32'(acc_m));
    endtask

    initial begin
        drive(1'b0, 2'b00, 8'h00);
        set_ready(1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(bus8.cmd_ready), 32'd0);
        check("rst_res_valid", 32'(bus8.res_valid), 32'd0);
        check("rst_res_data", 32'(bus8.res_data), 32'd0);
        check("rst_res_ovfl", 32'(bus8.res_ovfl), 32'd0);
        check("rst_sticky", 32'(bus8.sticky_ovfl), 32'd0);
        check("rst_op_count", 32'(bus8.op_count), 32'd0);
        check("rst_add_a", 32'(bus8.add_a), 32'd0);
        check("rst_add_b", 32'(bus8.add_b), 32'd0);
        check("rst_add_sub", 32'(bus8.add_sub), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_cmd_ready", 32'(bus8.cmd_ready), 32'd1);

        send(OP_LOAD, 8'h05); recv(0);
        send(OP_ADD,  8'h03); recv(0);
        send(OP_LOAD, 8'h7F); recv(0);
        send(OP_ADD,  8'h01); recv(0);
        send(OP_LOAD, 8'h10); recv(0);
        send(OP_LOAD, 8'h80); recv(0);
        send(OP_SUB,  8'h01); recv(0);
        send(OP_CLR,  8'h99); recv(0);

        set_ready(1'b0);
        send(OP_ADD, 8'h05); recv(5);
        send(OP_LOAD, 8'h33); recv(0);
        send(OP_ADD, 8'hFF); recv(0);
        send(OP_SUB, 8'h40); recv(0);

        send(OP_LOAD, 8'h20); recv(0);
        send(OP_ADD, 8'h01);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check("mid_rst_acc", 32'(bus8.add_a), 32'd0);
        check("mid_rst_valid", 32'(bus8.res_valid), 32'd0);
        check("mid_rst_count", 32'(bus8.op_count), 32'd0);
        check("mid_rst_count2", 32'(bus2.op_count), 32'd0);
        check("mid_rst_cmd_ready", 32'(bus8.cmd_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_cmd_ready", 32'(bus8.cmd_ready), 32'd1);
        check("mid_rel_valid", 32'(bus8.res_valid), 32'd0);

        send(OP_ADD, 8'h10); recv(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/accum_ctrl8.md
ACCUM_CTRL8 -- requirements
Module: accum_ctrl8

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 8, width of the completed-operation counter.
REQ-002 Ports SHALL be as follows; clk and rst_n are listed first.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block accepts a command this cycle.
- cmd_op  input  2  opcode: 00 LOAD, 01 ADD, 10 SUB, 11 CLR.
- cmd_data  input  8  operand.
- add_a  output  8  to add/sub unit operand a.
- add_b  output  8  to add/sub unit operand b.
- add_sub  output  1  to add/sub unit Sub select.
- add_s  input  8  sum/difference from add/sub unit (combinational).
- add_ovfl  input  1  signed overflow from add/sub unit.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_data  output  8  accumulator value after the command.
- res_ovfl  output  1  overflow of this command (ADD/SUB only).
- sticky_ovfl  output  1  OR of all overflows since the last reset or CLR.
- op_count  output  CNT_W  number of completed commands, saturating.
REQ-003 The design SHALL use a single clock, clk; reset SHALL be synchronous and active-low on rst_n.

Function
REQ-004 The FSM SHALL have three states: IDLE, EXEC, and RESP.
REQ-005 In IDLE, cmd_ready SHALL be 1; in all other states it SHALL be 0.
REQ-006 On cmd_valid && cmd_ready, the block SHALL register cmd_op and cmd_data and move to EXEC; otherwise it SHALL stay in IDLE.
REQ-007 EXEC SHALL last exactly one cycle and SHALL drive add_a=acc, add_b=registered operand, and add_sub=1 only for SUB (0 otherwise).
REQ-008 At the end of EXEC, the block SHALL update the accumulator as follows:
- LOAD: acc<=operand.
- ADD or SUB: acc<=add_s.
- CLR: acc<=0.
REQ-009 res_ovfl SHALL be set to add_ovfl for ADD/SUB and to 0 for LOAD/CLR.
REQ-010 sticky_ovfl SHALL be set by any ADD/SUB with add_ovfl=1, SHALL be cleared only by CLR or reset, and SHALL never be cleared by LOAD.
REQ-011 Outside EXEC, add_a SHALL equal acc, add_b SHALL be 0, and add_sub SHALL be 0.
REQ-012 At the end of EXEC, op_count SHALL increment by 1 and SHALL saturate at 2^CNT_W-1 (no wrap); CLR SHALL NOT reset op_count.
REQ-013 The FSM SHALL go from EXEC to RESP, and res_valid SHALL be 1 only in RESP.
REQ-014 res_data and res_ovfl SHALL be registered and SHALL hold stable while res_valid && !res_ready.
REQ-015 On res_valid && res_ready, the FSM SHALL go from RESP to IDLE; there is no direct RESP-to-IDLE-with-accept in the same cycle.
REQ-016 Command-accept to res_valid latency SHALL be 2 cycles; with res_ready held at 1, throughput SHALL be one command per 3 cycles.
REQ-017 Arithmetic SHALL be 8-bit two's complement and SHALL wrap modulo 256; overflow is reported via add_ovfl only, never saturated.
REQ-018 cmd_op/cmd_data changes while cmd_ready=0 SHALL have no effect.

Reset
REQ-019 When rst_n=0 at a clock edge, the following SHALL take effect regardless of state, including mid-EXEC and mid-RESP:
- FSM to IDLE, acc=0x00.
- res_valid=0, res_data=0x00, res_ovfl=0.
- sticky_ovfl=0, op_count=0.
- add_a=0x00, add_b=0x00, add_sub=0.
REQ-020 A command in EXEC when reset is asserted SHALL be discarded without updating acc or op_count.
REQ-021 cmd_ready SHALL be 0 during reset and SHALL be 1 in the first cycle after rst_n returns to 1.

Verification
REQ-022 LOAD 0x05 then ADD 0x03 (res_ready=1) -> res_data 0x05 then 0x08, res_ovfl 0, sticky 0, op_count 2.
REQ-023 LOAD 0x7F, ADD 0x01 -> res_data 0x80, res_ovfl 1, sticky_ovfl 1; then LOAD 0x10 -> res_ovfl 0, sticky_ovfl stays 1.
REQ-024 LOAD 0x80, SUB 0x01 -> add_sub=1 during EXEC, res_data 0x7F, res_ovfl 1; then CLR -> res_data 0x00, sticky_ovfl 0.
REQ-025 res_ready=0 for 5 cycles in RESP -> res_valid, res_data, and res_ovfl stable; cmd_ready 0 throughout; the next command is accepted in the cycle after the handshake.
REQ-026 rst_n pulled low during EXEC of ADD 0x01 on acc=0x20 -> next cycle acc=0, res_valid 0, op_count 0, cmd_ready 1 after release.
REQ-027 With CNT_W=2, issue 5 commands -> op_count reads 1, 2, 3, 3, 3.
